// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer for a single-issue RISC-V datapath:
// steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables and selects.
module multicycle_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 branch_cond,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_load,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic [1:0]           alu_op_type,
    output logic                 alu_src_b,
    output logic                 reg_write_en,
    output logic [1:0]           wb_sel,
    output logic                 instr_retired,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 illegal_instr
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    state_t                 state, state_next;
    logic [6:0]             op_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   illegal_q;

    logic       mem_req_c, mem_we_c, addr_sel_c, ir_load_c, pc_write_c;
    logic [1:0] pc_src_c, alu_op_c, wb_sel_c;
    logic       alu_src_b_c, reg_write_c, retire_c;

    logic is_r, is_load, is_store, is_branch, is_jal, is_jalr, is_imm_alu;
    assign is_r       = (op_q == OP_R);
    assign is_load    = (op_q == OP_LOAD);
    assign is_store   = (op_q == OP_STORE);
    assign is_branch  = (op_q == OP_BRANCH);
    assign is_jal     = (op_q == OP_JAL);
    assign is_jalr    = (op_q == OP_JALR);
    assign is_imm_alu = (op_q == OP_I) || (op_q == OP_LUI) || (op_q == OP_AUIPC) || is_jalr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                op_q <= opcode;
            if (retire_c)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            illegal_q <= illegal_q | (state_next == S_TRAP);
        end
    end

    always_comb begin
        state_next  = state;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        addr_sel_c  = 1'b0;
        ir_load_c   = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 2'b00;
        alu_op_c    = 2'b00;
        alu_src_b_c = 1'b0;
        reg_write_c = 1'b0;
        wb_sel_c    = 2'b00;
        retire_c    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_load_c  = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = legal_op(opcode) ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (is_r) begin
                    alu_op_c   = 2'b10;
                    state_next = S_WRITEBACK;
                end else if (is_imm_alu) begin
                    alu_src_b_c = 1'b1;
                    state_next  = S_WRITEBACK;
                end else if (is_load || is_store) begin
                    alu_src_b_c = 1'b1;
                    state_next  = S_MEMORY;
                end else if (is_branch) begin
                    // Branches resolve and retire here; no writeback stage needed.
                    alu_op_c   = 2'b01;
                    pc_write_c = 1'b1;
                    pc_src_c   = branch_cond ? 2'b01 : 2'b00;
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_req_c   = 1'b1;
                addr_sel_c  = 1'b1;
                alu_src_b_c = 1'b1;
                mem_we_c    = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write_c = 1'b1;
                        retire_c   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                retire_c    = 1'b1;
                wb_sel_c    = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
                pc_src_c    = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                // Hold the immediate on operand B so the JALR target stays stable.
                alu_src_b_c = is_jalr;
                state_next  = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset silences every output, including any in-flight retire or writes.
    assign mem_req       = mem_req_c   & ~rst;
    assign mem_we        = mem_we_c    & ~rst;
    assign addr_sel      = addr_sel_c  & ~rst;
    assign ir_load       = ir_load_c   & ~rst;
    assign pc_write      = pc_write_c  & ~rst;
    assign pc_src        = rst ? 2'b00 : pc_src_c;
    assign alu_op_type   = rst ? 2'b00 : alu_op_c;
    assign alu_src_b     = alu_src_b_c & ~rst;
    assign reg_write_en  = reg_write_c & ~rst;
    assign wb_sel        = rst ? 2'b00 : wb_sel_c;
    assign instr_retired = retire_c    & ~rst;
    assign retired_count = rst ? '0 : cnt_q;
    assign illegal_instr = illegal_q   & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and randomized instructions checked
// against per-instruction latency, enable counts and select values.
module tb_multicycle_controller;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          branch_cond;
    logic          mem_ready;
    logic          mem_req, mem_we, addr_sel, ir_load, pc_write;
    logic [1:0]    pc_src, alu_op_type, wb_sel;
    logic          alu_src_b, reg_write_en, instr_retired, illegal_instr;
    logic [CW-1:0] retired_count;

    int passed = 0;
    int total  = 0;
    int cnt_model = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_load(ir_load), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op_type(alu_op_type), .alu_src_b(alu_src_b),
        .reg_write_en(reg_write_en), .wb_sel(wb_sel),
        .instr_retired(instr_retired), .retired_count(retired_count),
        .illegal_instr(illegal_instr)
    );

    logic [18:0] all_out;
    assign all_out = {mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src,
                      alu_op_type, alu_src_b, reg_write_en, wb_sel,
                      instr_retired, illegal_instr, retired_count};

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_instr(input logic [6:0] op, input bit bc, input int fw, input int mw);
        int k = 0, episode = 0, waited = 0, lat = 0, exp_lat;
        int n_req = 0, n_we = 0, n_as = 0, n_ir = 0, n_pcw = 0, n_rw = 0, n_ret = 0;
        bit prev_ir = 0, done = 0;
        bit is_ld, is_st, is_ls, is_br, is_j, writes, exp_srcb;
        logic [1:0] psrc = 2'b11, wsel = 2'b11, exp_alu, exp_psrc, exp_wsel;
        is_ld  = (op == LD);
        is_st  = (op == ST);
        is_ls  = is_ld || is_st;
        is_br  = (op == BR);
        is_j   = (op == JAL) || (op == JALR);
        writes = !(is_br || is_st);
        exp_lat  = is_br ? 3 + fw : (is_ld ? 5 : 4) + fw + (is_ls ? mw : 0);
        exp_alu  = (op == R) ? 2'b10 : (is_br ? 2'b01 : 2'b00);
        exp_srcb = is_ls || op inside {I, LUI, AUIPC, JALR};
        exp_psrc = is_br ? {1'b0, bc} : (op == JAL) ? 2'b01 : (op == JALR) ? 2'b10 : 2'b00;
        exp_wsel = !writes ? 2'b00 : is_ld ? 2'b01 : is_j ? 2'b10 : 2'b00;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            opcode      = prev_ir ? op : 7'($urandom);
            branch_cond = bc;
            if (mem_req) mem_ready = (waited >= ((episode == 0) ? fw : mw));
            else         mem_ready = 1'($urandom);
            #1;
            n_req += int'(mem_req);  n_we  += int'(mem_we);   n_as  += int'(addr_sel);
            n_ir  += int'(ir_load);  n_pcw += int'(pc_write); n_rw  += int'(reg_write_en);
            n_ret += int'(instr_retired);
            if (k == fw + 3) begin
                chk("exec_alu_op_type", 32'(alu_op_type), 32'(exp_alu));
                chk("exec_alu_src_b", 32'(alu_src_b), 32'(exp_srcb));
            end
            if (mem_req) begin
                if (mem_ready) begin episode++; waited = 0; end
                else waited++;
            end
            prev_ir = ir_load;
            if (instr_retired) begin
                lat = k; psrc = pc_src; wsel = wb_sel; done = 1;
            end
        end
        chk("retired_in_budget", 32'(done), 32'd1);
        chk("latency", lat, exp_lat);
        chk("mem_req_cycles", n_req, 1 + fw + (is_ls ? 1 + mw : 0));
        chk("mem_we_cycles", n_we, is_st ? 1 + mw : 0);
        chk("addr_sel_cycles", n_as, is_ls ? 1 + mw : 0);
        chk("ir_load_count", n_ir, 1);
        chk("pc_write_count", n_pcw, 1);
        chk("reg_write_count", n_rw, writes ? 1 : 0);
        chk("retire_count", n_ret, 1);
        chk("retire_pc_src", 32'(psrc), 32'(exp_psrc));
        chk("retire_wb_sel", 32'(wsel), 32'(exp_wsel));
        cnt_model = (cnt_model + 1) % (1 << CW);
        @(posedge clk);
        #1;
        chk("retired_count", 32'(retired_count), cnt_model);
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk({tag, "_outputs_zero"}, 32'(all_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk({tag, "_fetch_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_illegal_clear"}, 32'(illegal_instr), 32'd0);
        chk({tag, "_count_zero"}, 32'(retired_count), 32'd0);
        cnt_model = 0;
        @(posedge clk);
    endtask

    task automatic run_illegal(input logic [6:0] op, input int fw);
        int nbad = 0;
        for (int k = 1; k <= fw + 2; k++) begin
            @(negedge clk);
            opcode    = (k == fw + 2) ? op : R;
            mem_ready = (k == fw + 1);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            opcode    = 7'($urandom);
            #1;
            if (mem_req || pc_write || reg_write_en || instr_retired || !illegal_instr) nbad++;
        end
        chk("trap_held", nbad, 0);
        chk("trap_count_frozen", 32'(retired_count), cnt_model);
        reset_and_check("trap_exit");
    endtask

    task automatic reset_in_memory();
        @(negedge clk); opcode = 7'($urandom); mem_ready = 1'b1;
        @(negedge clk); opcode = LD;           mem_ready = 1'b0;
        @(negedge clk); opcode = 7'($urandom);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        chk("rstmem_in_memory", 32'(addr_sel), 32'd1);
        reset_and_check("rstmem");
    endtask

    initial begin
        logic [6:0] legal_ops [9] = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC};
        logic [6:0] bad;
        rst = 1'b1; opcode = '0; branch_cond = 1'b0; mem_ready = 1'b0;
        reset_and_check("por");

        run_instr(R, 0, 0, 0);
        run_instr(LD, 0, 0, 2);
        run_instr(ST, 0, 0, 0);
        run_instr(BR, 1, 0, 0);
        run_instr(BR, 0, 0, 0);
        run_instr(JAL, 0, 0, 0);
        run_instr(JALR, 0, 0, 0);
        run_instr(LUI, 0, 1, 0);
        run_instr(AUIPC, 1, 2, 0);
        run_instr(ST, 1, 1, 3);

        run_illegal(7'b1111111, 0);
        reset_in_memory();

        for (int n = 0; n < 40; n++)
            run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2));

        do bad = 7'($urandom); while (is_legal(bad));
        run_illegal(bad, 1);
        run_instr(R, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
